airlock_pressure_controller: RTL and testbench

- Command-side counterpart of the chamber pressure model. It issues level-held startPressurization / startDepressurization and consumes the 8-bit pressure reading, deciding when a pump cycle has completed.
- It takes operator requests, interlocks them against door-closed sensors, and enforces settle and timeout rules.
- Door-unlock enables go to the door logic. Sits between the operator console and the Pressure block in the airlock top level.

---
 rtl/airlock_pressure_controller_pkg.sv | 24 ++
 rtl/airlock_pressure_controller_settle_counter.sv | 36 +++
 rtl/airlock_pressure_controller.sv | 134 +++++++++++++
 tb/tb_airlock_pressure_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/airlock_pressure_controller_pkg.sv
// Shared definitions for the airlock pressure controller: state encoding and
// default pressure thresholds used by the controller, the pressure model and benches.
package airlock_pressure_controller_pkg;

  typedef enum logic [2:0] {
    S_INIT           = 3'd0,
    S_PRESSURIZED    = 3'd1,
    S_DEPRESSURIZING = 3'd2,
    S_DEPRESSURIZED  = 3'd3,
    S_PRESSURIZING   = 3'd4,
    S_FAULT          = 3'd5
  } state_e;

  localparam logic [7:0] PRESS_HI_DEFAULT = 8'hF0;
  localparam logic [7:0] PRESS_LO_DEFAULT = 8'h10;
  localparam int         SETTLE_DEFAULT   = 4;
  localparam int         TIMEOUT_DEFAULT  = 64;
  localparam int         TIMER_W_DEFAULT  = 8;

  function automatic logic is_pump_state(input state_e s);
    return (s == S_PRESSURIZING) || (s == S_DEPRESSURIZING);
  endfunction

endpackage

// File: rtl/airlock_pressure_controller_settle_counter.sv
// Saturating run-length counter: counts consecutive enabled cycles with cond high
// and flags the cycle on which the run reaches TARGET.
module settle_counter #(
  parameter int WIDTH  = 4,
  parameter int TARGET = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic cond,
  output logic done
);

  localparam logic [WIDTH-1:0] COUNT_MAX  = '1;
  localparam logic [WIDTH-1:0] COUNT_LAST = WIDTH'(TARGET - 1);

  logic [WIDTH-1:0] r_count;

  // done marks the edge on which the count would become TARGET, so the caller
  // can change state on that same edge.
  assign done = en && cond && (r_count >= COUNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr || !en || !cond) begin
      r_count <= '0;
    end else if (r_count != COUNT_MAX) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/airlock_pressure_controller.sv
// Airlock command controller: interlocks operator pump requests against door
// sensors, drives level-held pump commands and enforces settle/timeout rules.
module airlock_pressure_controller
  import airlock_pressure_controller_pkg::*;
#(
  parameter logic [7:0] PRESS_HI = PRESS_HI_DEFAULT,
  parameter logic [7:0] PRESS_LO = PRESS_LO_DEFAULT,
  parameter int         SETTLE   = SETTLE_DEFAULT,
  parameter int         TIMEOUT  = TIMEOUT_DEFAULT,
  parameter int         TIMER_W  = TIMER_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] pressure,
  input  logic       req_press,
  input  logic       req_depress,
  input  logic       inner_closed,
  input  logic       outer_closed,
  input  logic       fault_clear,
  output logic       startPressurization,
  output logic       startDepressurization,
  output logic       inner_unlock,
  output logic       outer_unlock,
  output logic       busy,
  output logic       fault
);

  state_e r_state;
  state_e w_next_state;

  logic w_doors_closed;
  logic w_pump;
  logic w_target_met;
  logic w_state_change;
  logic w_settled;
  logic w_timed_out;

  logic r_start_press;
  logic r_start_depress;
  logic r_inner_unlock;
  logic r_outer_unlock;
  logic r_busy;
  logic r_fault;

  assign w_doors_closed = inner_closed && outer_closed;
  assign w_pump         = is_pump_state(r_state);
  assign w_target_met   = (r_state == S_PRESSURIZING) ? (pressure >= PRESS_HI)
                                                      : (pressure <= PRESS_LO);
  assign w_state_change = (w_next_state != r_state);

  settle_counter #(
    .WIDTH  (4),
    .TARGET (SETTLE)
  ) u_settle (
    .clk   (clock),
    .rst_n (reset),
    .clr   (w_state_change),
    .en    (w_pump),
    .cond  (w_target_met),
    .done  (w_settled)
  );

  settle_counter #(
    .WIDTH  (TIMER_W),
    .TARGET (TIMEOUT)
  ) u_timeout (
    .clk   (clock),
    .rst_n (reset),
    .clr   (w_state_change),
    .en    (w_pump),
    .cond  (1'b1),
    .done  (w_timed_out)
  );

  // NOTE: the next state gets a default before the case so no path through this
  // block leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_INIT: begin
        if (pressure >= PRESS_HI)      w_next_state = S_PRESSURIZED;
        else if (pressure <= PRESS_LO) w_next_state = S_DEPRESSURIZED;
        else                           w_next_state = S_PRESSURIZING;
      end
      S_PRESSURIZED: begin
        if (req_depress && w_doors_closed) w_next_state = S_DEPRESSURIZING;
      end
      S_DEPRESSURIZED: begin
        if (req_press && w_doors_closed) w_next_state = S_PRESSURIZING;
      end
      S_DEPRESSURIZING, S_PRESSURIZING: begin
        // Door interlock outranks settle, which outranks timeout.
        if (!w_doors_closed) w_next_state = S_FAULT;
        else if (w_settled)  w_next_state = (r_state == S_PRESSURIZING) ? S_PRESSURIZED
                                                                        : S_DEPRESSURIZED;
        else if (w_timed_out) w_next_state = S_FAULT;
      end
      S_FAULT: begin
        if (fault_clear && w_doors_closed) w_next_state = S_INIT;
      end
      default: w_next_state = S_INIT;
    endcase
  end

  // Outputs are decoded from the next state so the two pump commands can never
  // overlap, even across a direct transition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_INIT;
      r_start_press   <= 1'b0;
      r_start_depress <= 1'b0;
      r_inner_unlock  <= 1'b0;
      r_outer_unlock  <= 1'b0;
      r_busy          <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_start_press   <= (w_next_state == S_PRESSURIZING);
      r_start_depress <= (w_next_state == S_DEPRESSURIZING);
      r_inner_unlock  <= (w_next_state == S_PRESSURIZED);
      r_outer_unlock  <= (w_next_state == S_DEPRESSURIZED);
      r_busy          <= is_pump_state(w_next_state);
      r_fault         <= (w_next_state == S_FAULT);
    end
  end

  assign startPressurization   = r_start_press;
  assign startDepressurization = r_start_depress;
  assign inner_unlock          = r_inner_unlock;
  assign outer_unlock          = r_outer_unlock;
  assign busy                  = r_busy;
  assign fault                 = r_fault;

endmodule

// File: tb/tb_airlock_pressure_controller.sv
// Bench for airlock_pressure_controller: directed scenarios plus a randomized run,
// all checked against a rule-level model of the airlock.
module tb_airlock_pressure_controller;

  localparam logic [7:0] HI      = airlock_pressure_controller_pkg::PRESS_HI_DEFAULT;
  localparam logic [7:0] LO      = airlock_pressure_controller_pkg::PRESS_LO_DEFAULT;
  localparam int         SETTLE  = 4;
  localparam int         TIMEOUT = 64;

  // Output vector order: {startP, startD, inner_unlock, outer_unlock, busy, fault}
  localparam logic [5:0] O_NONE      = 6'b000000;
  localparam logic [5:0] O_HIGH      = 6'b001000;
  localparam logic [5:0] O_LOW       = 6'b000100;
  localparam logic [5:0] O_PUMP_UP   = 6'b100010;
  localparam logic [5:0] O_PUMP_DOWN = 6'b010010;
  localparam logic [5:0] O_FAULT     = 6'b000001;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pressure = 8'hFF;
  logic       req_press = 1'b0;
  logic       req_depress = 1'b0;
  logic       inner_closed = 1'b1;
  logic       outer_closed = 1'b1;
  logic       fault_clear = 1'b0;
  logic       startPressurization;
  logic       startDepressurization;
  logic       inner_unlock;
  logic       outer_unlock;
  logic       busy;
  logic       fault;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  airlock_pressure_controller dut (
    .clock                 (clock),
    .reset                 (reset),
    .pressure              (pressure),
    .req_press             (req_press),
    .req_depress           (req_depress),
    .inner_closed          (inner_closed),
    .outer_closed          (outer_closed),
    .fault_clear           (fault_clear),
    .startPressurization   (startPressurization),
    .startDepressurization (startDepressurization),
    .inner_unlock          (inner_unlock),
    .outer_unlock          (outer_unlock),
    .busy                  (busy),
    .fault                 (fault)
  );

  wire [5:0] observed = {startPressurization, startDepressurization, inner_unlock,
                         outer_unlock, busy, fault};

  // Rule-level airlock model: a mode plus cycles spent pumping and the current run
  // of consecutive on-target readings.
  typedef enum {M_INIT, M_HIGH, M_GOING_LOW, M_LOW, M_GOING_HIGH, M_FAULT} mode_t;
  mode_t m_mode = M_INIT;
  int    m_cycles = 0;
  int    m_run = 0;

  task automatic enter(input mode_t m);
    m_mode   = m;
    m_cycles = 0;
    m_run    = 0;
  endtask

  task automatic model_step();
    logic doors;
    logic on_target;
    doors = inner_closed && outer_closed;
    case (m_mode)
      M_INIT:
        if (pressure >= HI)      enter(M_HIGH);
        else if (pressure <= LO) enter(M_LOW);
        else                     enter(M_GOING_HIGH);
      M_HIGH: if (req_depress && doors) enter(M_GOING_LOW);
      M_LOW:  if (req_press && doors)   enter(M_GOING_HIGH);
      M_GOING_LOW, M_GOING_HIGH: begin
        if (!doors) enter(M_FAULT);
        else begin
          on_target = (m_mode == M_GOING_HIGH) ? (pressure >= HI) : (pressure <= LO);
          m_cycles  = m_cycles + 1;
          m_run     = on_target ? m_run + 1 : 0;
          if (m_run >= SETTLE)         enter(m_mode == M_GOING_HIGH ? M_HIGH : M_LOW);
          else if (m_cycles >= TIMEOUT) enter(M_FAULT);
        end
      end
      default: if (fault_clear && doors) enter(M_INIT);
    endcase
  endtask

  function automatic logic [5:0] expected_outputs();
    return {m_mode == M_GOING_HIGH, m_mode == M_GOING_LOW, m_mode == M_HIGH,
            m_mode == M_LOW, (m_mode == M_GOING_HIGH) || (m_mode == M_GOING_LOW),
            m_mode == M_FAULT};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pressure = 8'hFF; inner_closed = 1'b1; outer_closed = 1'b1;
    enter(M_INIT);
    repeat (2) @(negedge clock);
    checks++;
    if (observed !== O_NONE) begin
      errors++; $display("FAIL reset_hold outputs got=%b exp=%b", observed, O_NONE);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (observed !== O_NONE) begin
      errors++; $display("FAIL reset_init_cycle outputs got=%b exp=%b", observed, O_NONE);
    end
    tick();
    checks++;
    if (observed !== O_HIGH || observed !== expected_outputs()) begin
      errors++; $display("FAIL reset_to_pressurized outputs got=%b exp=%b", observed, O_HIGH);
    end
  endtask

  task automatic test_depress_cycle();
    int  low_edges = 0;
    bit  done = 0;
    req_depress = 1'b1;
    tick();
    req_depress = 1'b0;
    checks++;
    if (observed !== O_PUMP_DOWN) begin
      errors++; $display("FAIL depress_start outputs got=%b exp=%b", observed, O_PUMP_DOWN);
    end
    for (int c = 1; c < 100 && !done; c++) begin
      pressure = (255 - 12 * c < 16) ? 8'h10 : 8'(255 - 12 * c);
      tick();
      if (pressure <= LO) low_edges++;
      checks++;
      if (observed !== expected_outputs()) begin
        errors++; $display("FAIL depress_ramp c=%0d got=%b exp=%b", c, observed, expected_outputs());
      end
      if (!startDepressurization) done = 1;
    end
    checks++;
    if (!done || low_edges != SETTLE || observed !== O_LOW) begin
      errors++;
      $display("FAIL depress_settle low_edges=%0d exp=%0d outputs=%b exp=%b", low_edges, SETTLE,
               observed, O_LOW);
    end
  endtask

  task automatic test_door_open_request();
    int high_edges = 0;
    bit done = 0;
    outer_closed = 1'b0; req_press = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (observed !== O_LOW) begin
        errors++; $display("FAIL door_open_ignored got=%b exp=%b", observed, O_LOW);
      end
    end
    outer_closed = 1'b1;
    tick();
    checks++;
    if (observed !== O_PUMP_UP) begin
      errors++; $display("FAIL press_start got=%b exp=%b", observed, O_PUMP_UP);
    end
    for (int c = 1; c < 100 && !done; c++) begin
      pressure = (16 + 12 * c > 255) ? 8'hFF : 8'(16 + 12 * c);
      tick();
      if (pressure >= HI) high_edges++;
      checks++;
      if (observed !== expected_outputs()) begin
        errors++; $display("FAIL press_ramp c=%0d got=%b exp=%b", c, observed, expected_outputs());
      end
      if (!startPressurization) done = 1;
    end
    req_press = 1'b0;
    checks++;
    if (!done || high_edges != SETTLE || observed !== O_HIGH) begin
      errors++;
      $display("FAIL press_settle high_edges=%0d exp=%0d outputs=%b exp=%b", high_edges, SETTLE,
               observed, O_HIGH);
    end
  endtask

  task automatic test_timeout();
    int fault_cycle = -1;
    pressure = 8'h10; req_depress = 1'b1;
    tick();
    req_depress = 1'b0;
    for (int c = 0; c < 20 && !outer_unlock; c++) tick();
    pressure = 8'h80; req_press = 1'b1;
    tick();
    req_press = 1'b0;
    checks++;
    if (observed !== O_PUMP_UP) begin
      errors++; $display("FAIL stuck_start got=%b exp=%b", observed, O_PUMP_UP);
    end
    for (int c = 1; c <= 100 && fault_cycle < 0; c++) begin
      tick();
      checks++;
      if (observed !== expected_outputs()) begin
        errors++; $display("FAIL stuck_pump c=%0d got=%b exp=%b", c, observed, expected_outputs());
      end
      if (fault) fault_cycle = c;
    end
    checks++;
    if (fault_cycle != TIMEOUT || observed !== O_FAULT) begin
      errors++; $display("FAIL stuck_timeout cycle got=%0d exp=%0d", fault_cycle, TIMEOUT);
    end
    inner_closed = 1'b0; fault_clear = 1'b1;
    tick();
    checks++;
    if (observed !== O_FAULT) begin
      errors++; $display("FAIL clear_door_open got=%b exp=%b", observed, O_FAULT);
    end
    inner_closed = 1'b1;
    tick();
    fault_clear = 1'b0;
    checks++;
    if (observed !== O_NONE) begin
      errors++; $display("FAIL clear_to_init got=%b exp=%b", observed, O_NONE);
    end
    tick();
    checks++;
    if (observed !== O_PUMP_UP || observed !== expected_outputs()) begin
      errors++; $display("FAIL init_midrange got=%b exp=%b", observed, O_PUMP_UP);
    end
  endtask

  task automatic test_dither();
    int fault_cycle = -1;
    for (int c = 1; c <= 100 && fault_cycle < 0; c++) begin
      pressure = c[0] ? 8'hF0 : 8'hEF;
      tick();
      checks++;
      if (observed !== expected_outputs()) begin
        errors++; $display("FAIL dither_pump c=%0d got=%b exp=%b", c, observed, expected_outputs());
      end
      if (fault) fault_cycle = c;
    end
    checks++;
    if (fault_cycle != TIMEOUT) begin
      errors++; $display("FAIL dither_timeout cycle got=%0d exp=%0d", fault_cycle, TIMEOUT);
    end
    pressure = 8'hFF; fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    tick();
    checks++;
    if (observed !== O_HIGH) begin
      errors++; $display("FAIL dither_recover got=%b exp=%b", observed, O_HIGH);
    end
  endtask

  task automatic test_interlock();
    req_depress = 1'b1;
    tick();
    req_depress = 1'b0;
    repeat (3) tick();
    checks++;
    if (observed !== O_PUMP_DOWN) begin
      errors++; $display("FAIL interlock_pumping got=%b exp=%b", observed, O_PUMP_DOWN);
    end
    inner_closed = 1'b0;
    tick();
    checks++;
    if (observed !== O_FAULT || observed !== expected_outputs()) begin
      errors++; $display("FAIL interlock_fault got=%b exp=%b", observed, O_FAULT);
    end
    inner_closed = 1'b1; fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    tick();
    checks++;
    if (observed !== O_HIGH) begin
      errors++; $display("FAIL interlock_recover got=%b exp=%b", observed, O_HIGH);
    end
  endtask

  task automatic test_reset_mid_pump();
    req_depress = 1'b1;
    tick();
    req_depress = 1'b0;
    tick();
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (observed !== O_NONE) begin
      errors++; $display("FAIL reset_mid_pump got=%b exp=%b", observed, O_NONE);
    end
    enter(M_INIT);
    pressure = 8'h80;
    @(negedge clock);
    reset = 1'b1;
    tick();
    checks++;
    if (observed !== O_PUMP_UP || observed !== expected_outputs()) begin
      errors++; $display("FAIL reset_reentry got=%b exp=%b", observed, O_PUMP_UP);
    end
  endtask

  task automatic test_random();
    int regime = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) regime = int'($urandom_range(0, 2));
      case (regime)
        0:       pressure = 8'($urandom_range(0, 16));
        1:       pressure = 8'($urandom_range(240, 255));
        default: pressure = 8'($urandom_range(0, 255));
      endcase
      req_press    = ($urandom_range(0, 7) == 0);
      req_depress  = ($urandom_range(0, 7) == 0);
      inner_closed = ($urandom_range(0, 49) != 0);
      outer_closed = ($urandom_range(0, 49) != 0);
      fault_clear  = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (observed !== expected_outputs()) begin
        errors++; $display("FAIL random c=%0d got=%b exp=%b", c, observed, expected_outputs());
      end
      checks++;
      if ((startPressurization && startDepressurization) || (inner_unlock && outer_unlock)) begin
        errors++; $display("FAIL random_exclusive c=%0d got=%b exp=no overlap", c, observed);
      end
    end
    req_press = 1'b0; req_depress = 1'b0; fault_clear = 1'b0;
    inner_closed = 1'b1; outer_closed = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_depress_cycle();
    test_door_open_request();
    test_timeout();
    test_dither();
    test_interlock();
    test_reset_mid_pump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
